// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exe_pkg
// Purpose  : Shared definitions for the execute stage: ALU command encodings,
//            barrel-shift type encodings, status-register bit positions and a
//            32-bit rotate-right helper.
// Revision : 1.0 - initial release
// ============================================================================
package exe_pkg;

   // ALU command encodings carried on EXE_CMD
   typedef enum logic [3:0] {
      CMD_MOV = 4'b0001,
      CMD_ADD = 4'b0010,
      CMD_ADC = 4'b0011,
      CMD_SUB = 4'b0100,
      CMD_SBC = 4'b0101,
      CMD_AND = 4'b0110,
      CMD_ORR = 4'b0111,
      CMD_EOR = 4'b1000,
      CMD_MVN = 4'b1001
   } exe_cmd_e;

   // Register-operand shift types (Shift_operand[6:5])
   typedef enum logic [1:0] {
      SHIFT_LSL = 2'b00,
      SHIFT_LSR = 2'b01,
      SHIFT_ASR = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_type_e;

   // Bit positions inside the 4-bit status register {N,Z,C,V}
   localparam int c_flag_n = 3;
   localparam int c_flag_z = 2;
   localparam int c_flag_c = 1;
   localparam int c_flag_v = 0;

   // Rotate right by 0..31; concatenating the word with itself lets a plain
   // logical shift produce the wrapped bits.
   function automatic logic [31:0] ror32(input logic [31:0] val,
                                         input logic [4:0]  amt);
      logic [63:0] w_dbl;
      w_dbl = {val, val} >> amt;
      return w_dbl[31:0];
   endfunction

endpackage : exe_pkg
`default_nettype wire

// File: rtl/exe_alu.sv
`default_nettype none
// ============================================================================
// Module   : exe_alu
// Purpose  : Execute-stage ALU with N/Z/C/V flag generation.
// Ports    : exe_cmd   in  4   ALU command (exe_pkg::exe_cmd_e encodings)
//            val_rn    in  32  first operand
//            val2      in  32  second operand (shifter output)
//            c_in      in  1   current registered carry flag
//            v_in      in  1   current registered overflow flag
//            alu_res   out 32  result (wraps modulo 2^32)
//            flags_out out 4   new {N,Z,C,V}
// Config   : EXE_OVF_FLAG_EN - when defined, V is the signed overflow of
//            add/sub; otherwise the overflow logic is not built and V of an
//            arithmetic command is 0.
// Revision : 1.0 - initial release
// ============================================================================
module exe_alu
   import exe_pkg::*;
(
   input  logic [3:0]  exe_cmd,
   input  logic [31:0] val_rn,
   input  logic [31:0] val2,
   input  logic        c_in,
   input  logic        v_in,
   output logic [31:0] alu_res,
   output logic [3:0]  flags_out
);

   logic [31:0] w_op_b;
   logic        w_cin;
   logic        w_arith;
   logic [32:0] w_sum;
   logic        w_ovf;

   // Subtraction is done as Rn + ~Val2 + cin so one adder serves all four
   // arithmetic commands and the carry-out is directly "NOT borrow".
   always_comb begin
      w_op_b  = val2;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      case (exe_cmd)
         CMD_ADD: begin
            w_arith = 1'b1;
         end
         CMD_ADC: begin
            w_arith = 1'b1;
            w_cin   = c_in;
         end
         CMD_SUB: begin
            w_arith = 1'b1;
            w_op_b  = ~val2;
            w_cin   = 1'b1;
         end
         CMD_SBC: begin
            w_arith = 1'b1;
            w_op_b  = ~val2;
            w_cin   = c_in;
         end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, val_rn} + {1'b0, w_op_b} + {32'd0, w_cin};

`ifdef EXE_OVF_FLAG_EN
   // Overflow when both adder inputs share a sign the result does not
   assign w_ovf = (val_rn[31] == w_op_b[31]) && (w_sum[31] != val_rn[31]);
`else
   assign w_ovf = 1'b0;
`endif

   always_comb begin
      alu_res = 32'd0;
      case (exe_cmd)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_ADD,
         CMD_ADC,
         CMD_SUB,
         CMD_SBC: alu_res = w_sum[31:0];
         CMD_AND: alu_res = val_rn & val2;
         CMD_ORR: alu_res = val_rn | val2;
         CMD_EOR: alu_res = val_rn ^ val2;
         default: alu_res = 32'd0;
      endcase
   end

   // C and V pass through unchanged for everything except add/sub
   always_comb begin
      flags_out           = 4'd0;
      flags_out[c_flag_n] = alu_res[31];
      flags_out[c_flag_z] = (alu_res == 32'd0);
      flags_out[c_flag_c] = w_arith ? w_sum[32] : c_in;
      flags_out[c_flag_v] = w_arith ? w_ovf     : v_in;
   end

endmodule : exe_alu
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage
// Purpose  : Execute pipeline stage: forms the second operand (immediate
//            rotate, memory offset or barrel-shifted Rm), runs the ALU,
//            keeps the {N,Z,C,V} status register, computes the branch target
//            and registers the EX/MEM outputs.
// Ports    : CLK, RST_N (async active-low), Stall (hold all registers)
//            WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In  controls
//            EXE_CMD_In[3:0], Dest_In[3:0], PC_In/Val_Rn_In/Val_Rm_In[31:0]
//            Shift_operand_In[11:0], Signed_imm_24_In[23:0]
//            SR[3:0]                  registered {N,Z,C,V}
//            Br_taken, Br_Addr[31:0]  combinational branch outputs
//            WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out, ALU_Res_Out, Val_Rm_Out,
//            Dest_Out                 EX/MEM register outputs
// Config   : EXE_OVF_FLAG_EN - enables the V flag (otherwise SR.V stays 0).
// Revision : 1.0 - initial release
// ============================================================================
module exe_stage
   import exe_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        Stall,
   input  logic        WB_EN_In,
   input  logic        MEM_R_EN_In,
   input  logic        MEM_W_EN_In,
   input  logic        B_In,
   input  logic        S_In,
   input  logic        imm_In,
   input  logic [3:0]  EXE_CMD_In,
   input  logic [3:0]  Dest_In,
   input  logic [31:0] PC_In,
   input  logic [31:0] Val_Rn_In,
   input  logic [31:0] Val_Rm_In,
   input  logic [11:0] Shift_operand_In,
   input  logic [23:0] Signed_imm_24_In,
   output logic [3:0]  SR,
   output logic        Br_taken,
   output logic [31:0] Br_Addr,
   output logic        WB_EN_Out,
   output logic        MEM_R_EN_Out,
   output logic        MEM_W_EN_Out,
   output logic [31:0] ALU_Res_Out,
   output logic [31:0] Val_Rm_Out,
   output logic [3:0]  Dest_Out
);

   logic [31:0] w_val2;
   logic [4:0]  w_rot_amt;
   logic [4:0]  w_sh_amt;
   logic [31:0] w_alu_res;
   logic [3:0]  w_flags;

   logic [3:0]  r_sr;
   logic        r_wb_en;
   logic        r_mem_r_en;
   logic        r_mem_w_en;
   logic [31:0] r_alu_res;
   logic [31:0] r_val_rm;
   logic [3:0]  r_dest;

   // Immediate form rotates by twice the 4-bit field
   assign w_rot_amt = {Shift_operand_In[11:8], 1'b0};
   assign w_sh_amt  = Shift_operand_In[11:7];

   always_comb begin
      w_val2 = Val_Rm_In;
      if (imm_In) begin
         w_val2 = ror32({24'd0, Shift_operand_In[7:0]}, w_rot_amt);
      end else if (MEM_R_EN_In || MEM_W_EN_In) begin
         w_val2 = {20'd0, Shift_operand_In};
      end else begin
         case (Shift_operand_In[6:5])
            SHIFT_LSL: w_val2 = Val_Rm_In << w_sh_amt;
            SHIFT_LSR: w_val2 = Val_Rm_In >> w_sh_amt;
            SHIFT_ASR: w_val2 = $unsigned($signed(Val_Rm_In) >>> w_sh_amt);
            SHIFT_ROR: w_val2 = ror32(Val_Rm_In, w_sh_amt);
            default:   w_val2 = Val_Rm_In;
         endcase
      end
   end

   // ADC/SBC see the carry registered before this edge, not the new one
   exe_alu u_alu (
      .exe_cmd   (EXE_CMD_In),
      .val_rn    (Val_Rn_In),
      .val2      (w_val2),
      .c_in      (r_sr[c_flag_c]),
      .v_in      (r_sr[c_flag_v]),
      .alu_res   (w_alu_res),
      .flags_out (w_flags)
   );

   assign Br_taken = B_In;
   assign Br_Addr  = PC_In + {{6{Signed_imm_24_In[23]}}, Signed_imm_24_In, 2'b00};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sr       <= 4'd0;
         r_wb_en    <= 1'b0;
         r_mem_r_en <= 1'b0;
         r_mem_w_en <= 1'b0;
         r_alu_res  <= 32'd0;
         r_val_rm   <= 32'd0;
         r_dest     <= 4'd0;
      end else if (!Stall) begin
         r_wb_en    <= WB_EN_In;
         r_mem_r_en <= MEM_R_EN_In;
         r_mem_w_en <= MEM_W_EN_In;
         r_alu_res  <= w_alu_res;
         r_val_rm   <= Val_Rm_In;
         r_dest     <= Dest_In;
         if (S_In) begin
            r_sr <= w_flags;
         end
      end
   end

   assign SR           = r_sr;
   assign WB_EN_Out    = r_wb_en;
   assign MEM_R_EN_Out = r_mem_r_en;
   assign MEM_W_EN_Out = r_mem_w_en;
   assign ALU_Res_Out  = r_alu_res;
   assign Val_Rm_Out   = r_val_rm;
   assign Dest_Out     = r_dest;

endmodule : exe_stage
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_exe_stage
// Purpose  : Self-checking bench for exe_stage: directed scenarios followed by
//            randomized traffic against an arithmetic reference model.
// Config   : EXE_OVF_FLAG_EN - must match the RTL build (selects V model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

`ifdef EXE_OVF_FLAG_EN
   localparam bit c_ovf_en = 1'b1;
`else
   localparam bit c_ovf_en = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        Stall = 1'b0;
   logic        WB_EN_In = 1'b0, MEM_R_EN_In = 1'b0, MEM_W_EN_In = 1'b0;
   logic        B_In = 1'b0, S_In = 1'b0, imm_In = 1'b0;
   logic [3:0]  EXE_CMD_In = 4'd0, Dest_In = 4'd0;
   logic [31:0] PC_In = 32'd0, Val_Rn_In = 32'd0, Val_Rm_In = 32'd0;
   logic [11:0] Shift_operand_In = 12'd0;
   logic [23:0] Signed_imm_24_In = 24'd0;
   logic [3:0]  SR;
   logic        Br_taken;
   logic [31:0] Br_Addr;
   logic        WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out;
   logic [31:0] ALU_Res_Out, Val_Rm_Out;
   logic [3:0]  Dest_Out;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [3:0]  m_sr   = 4'd0;
   logic [31:0] m_res  = 32'd0;
   logic [31:0] m_rm   = 32'd0;
   logic [3:0]  m_dest = 4'd0;
   logic [2:0]  m_ctl  = 3'd0;

   always #5 CLK = ~CLK;

   exe_stage dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .Stall            (Stall),
      .WB_EN_In         (WB_EN_In),
      .MEM_R_EN_In      (MEM_R_EN_In),
      .MEM_W_EN_In      (MEM_W_EN_In),
      .B_In             (B_In),
      .S_In             (S_In),
      .imm_In           (imm_In),
      .EXE_CMD_In       (EXE_CMD_In),
      .Dest_In          (Dest_In),
      .PC_In            (PC_In),
      .Val_Rn_In        (Val_Rn_In),
      .Val_Rm_In        (Val_Rm_In),
      .Shift_operand_In (Shift_operand_In),
      .Signed_imm_24_In (Signed_imm_24_In),
      .SR               (SR),
      .Br_taken         (Br_taken),
      .Br_Addr          (Br_Addr),
      .WB_EN_Out        (WB_EN_Out),
      .MEM_R_EN_Out     (MEM_R_EN_Out),
      .MEM_W_EN_Out     (MEM_W_EN_Out),
      .ALU_Res_Out      (ALU_Res_Out),
      .Val_Rm_Out       (Val_Rm_Out),
      .Dest_Out         (Dest_Out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      longint unsigned v;
      v = 64'(x);
      if (n == 0) return x;
      return 32'(((v >> n) | (v << (32 - n))) & 64'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                          input logic [11:0] so, input logic [31:0] rm);
      int amt;
      logic [31:0] q;
      if (imm) return rotr({24'd0, so[7:0]}, 2 * int'(so[11:8]));
      if (mem) return 32'(so);
      amt = int'(so[11:7]);
      case (so[6:5])
         2'd0: q = 32'(64'(rm) * (64'd1 << amt));
         2'd1: q = rm / (32'd1 << amt);
         2'd2: begin
            q = rm / (32'd1 << amt);
            if (rm[31] && amt > 0) q = q | ~(32'hFFFF_FFFF >> amt);
         end
         default: q = rotr(rm, amt);
      endcase
      return q;
   endfunction

   task automatic m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                        input logic [3:0] sr, output logic [31:0] res, output logic [3:0] nsr);
      longint d, s, cin;
      logic c, v;
      c = sr[1];
      v = sr[0];
      res = 32'd0;
      case (cmd)
         4'd1: res = v2;
         4'd9: res = ~v2;
         4'd2, 4'd3: begin
            cin = (cmd == 4'd3) ? longint'(sr[1]) : 0;
            d = longint'(rn) + longint'(v2) + cin;
            s = longint'($signed(rn)) + longint'($signed(v2)) + cin;
            res = 32'(d);
            c = (d > 64'sd4294967295);
            v = c_ovf_en && (s > 64'sd2147483647 || s < -64'sd2147483648);
         end
         4'd4, 4'd5: begin
            cin = (cmd == 4'd5) ? longint'(!sr[1]) : 0;
            d = longint'(rn) - longint'(v2) - cin;
            s = longint'($signed(rn)) - longint'($signed(v2)) - cin;
            res = 32'(d);
            c = (d >= 0);
            v = c_ovf_en && (s > 64'sd2147483647 || s < -64'sd2147483648);
         end
         4'd6: res = rn & v2;
         4'd7: res = rn | v2;
         4'd8: res = rn ^ v2;
         default: res = 32'd0;
      endcase
      nsr = {res[31], res == 32'd0, c, v};
   endtask

   task automatic m_reset();
      m_sr = 4'd0; m_res = 32'd0; m_rm = 32'd0; m_dest = 4'd0; m_ctl = 3'd0;
   endtask

   task automatic chk_regs(input string pfx);
      chk({pfx, "_res"},  ALU_Res_Out, m_res);
      chk({pfx, "_rm"},   Val_Rm_Out, m_rm);
      chk({pfx, "_dest"}, 32'(Dest_Out), 32'(m_dest));
      chk({pfx, "_ctl"},  32'({WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out}), 32'(m_ctl));
      chk({pfx, "_sr"},   32'(SR), 32'(m_sr));
   endtask

   // Inputs are applied at the falling edge; this checks the combinational
   // branch outputs, advances one rising edge and checks the registers.
   task automatic cycle(input string pfx);
      logic [31:0] v2, res;
      logic [3:0]  nsr;
      longint off;
      #1;
      off = Signed_imm_24_In[23] ? longint'(Signed_imm_24_In) - 64'sd16777216
                                 : longint'(Signed_imm_24_In);
      chk({pfx, "_br_taken"}, 32'(Br_taken), 32'(B_In));
      chk({pfx, "_br_addr"}, Br_Addr, 32'(longint'(PC_In) + off * 4));
      v2 = m_val2(imm_In, MEM_R_EN_In | MEM_W_EN_In, Shift_operand_In, Val_Rm_In);
      m_alu(EXE_CMD_In, Val_Rn_In, v2, m_sr, res, nsr);
      @(posedge CLK);
      if (!Stall) begin
         m_res = res; m_rm = Val_Rm_In; m_dest = Dest_In;
         m_ctl = {WB_EN_In, MEM_R_EN_In, MEM_W_EN_In};
         if (S_In) m_sr = nsr;
      end
      #1;
      chk_regs(pfx);
      @(negedge CLK);
   endtask

   task automatic drive(input logic [3:0] cmd, input logic s, input logic imm,
                        input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
      EXE_CMD_In = cmd; S_In = s; imm_In = imm; Shift_operand_In = so;
      Val_Rn_In = rn; Val_Rm_In = rm;
      WB_EN_In = 1'b1; MEM_R_EN_In = 1'b0; MEM_W_EN_In = 1'b0; B_In = 1'b0;
      Stall = 1'b0;
      Dest_In = 4'($urandom);
      PC_In = $urandom;
      Signed_imm_24_In = 24'($urandom);
   endtask

   initial begin
      // Reset held: outputs zero even with clocks and Stall toggling
      RST_N = 1'b0;
      drive(4'd2, 1'b1, 1'b1, 12'h0FF, 32'h1234_5678, 32'hDEAD_BEEF);
      repeat (2) @(posedge CLK);
      Stall = 1'b1;
      @(posedge CLK); #1;
      m_reset();
      chk_regs("reset");
      @(negedge CLK);
      RST_N = 1'b1;

      // First edge after reset captures; ADD overflow into sign bit
      drive(4'd2, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0000_0011);
      cycle("add_ovf");
      chk("add_ovf_res_k", ALU_Res_Out, 32'h8000_0000);
      chk("add_ovf_sr_k", 32'(SR), 32'({3'b100, c_ovf_en}));

      // SUB to zero then ADC consuming the registered carry
      drive(4'd4, 1'b1, 1'b1, 12'h005, 32'd5, 32'd0);
      cycle("sub_zero");
      chk("sub_zero_sr_k", 32'(SR), 32'h6);
      drive(4'd3, 1'b0, 1'b1, 12'h001, 32'd1, 32'd0);
      cycle("adc");
      chk("adc_res_k", ALU_Res_Out, 32'd3);

      // Immediate rotate and register ASR operands through MOV
      drive(4'd1, 1'b0, 1'b1, 12'h4FF, 32'd0, 32'd0);
      cycle("imm_rot");
      chk("imm_rot_k", ALU_Res_Out, 32'hFF00_0000);
      drive(4'd1, 1'b0, 1'b0, 12'h240, 32'd0, 32'h8000_0010);
      cycle("asr4");
      chk("asr4_k", ALU_Res_Out, 32'hF800_0001);

      // Memory offset form
      drive(4'd2, 1'b0, 1'b0, 12'hABC, 32'h100, 32'h5555);
      MEM_R_EN_In = 1'b1;
      cycle("mem_off");
      chk("mem_off_k", ALU_Res_Out, 32'h0000_0BBC);

      // Branch outputs combinational in the same cycle
      drive(4'd0, 1'b0, 1'b0, 12'h000, 32'd0, 32'd0);
      B_In = 1'b1; PC_In = 32'h100; Signed_imm_24_In = 24'hFFFFFE;
      #1;
      chk("branch_taken_k", 32'(Br_taken), 32'd1);
      chk("branch_addr_k", Br_Addr, 32'h0000_00F8);
      cycle("branch");

      // Set a known SR, then stall three cycles with S=1 on a different op
      drive(4'd4, 1'b1, 1'b1, 12'h001, 32'd0, 32'h77);
      cycle("pre_stall");
      for (int i = 0; i < 3; i++) begin
         drive(4'd2, 1'b1, 1'b1, 12'h0FF, 32'h10, 32'h99);
         Stall = 1'b1;
         cycle("stall");
         chk("stall_sr_k", 32'(SR), 32'h8);
         chk("stall_res_k", ALU_Res_Out, 32'hFFFF_FFFF);
      end

      // Reset pulsed mid-cycle discards a pending flag-setting op
      drive(4'd4, 1'b1, 1'b1, 12'h001, 32'd0, 32'h1);
      #2 RST_N = 1'b0;
      #1;
      m_reset();
      chk_regs("async_rst");
      @(posedge CLK); #1;
      chk_regs("async_rst_hold");
      @(negedge CLK);
      RST_N = 1'b1;
      drive(4'd1, 1'b0, 1'b1, 12'h0AA, 32'd0, 32'd0);
      cycle("post_rst");

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         EXE_CMD_In = 4'($urandom_range(0, 15));
         S_In = 1'($urandom);
         imm_In = ($urandom_range(0, 2) == 0);
         MEM_R_EN_In = ($urandom_range(0, 4) == 0);
         MEM_W_EN_In = ($urandom_range(0, 4) == 0);
         WB_EN_In = 1'($urandom);
         B_In = 1'($urandom);
         Stall = ($urandom_range(0, 4) == 0);
         Dest_In = 4'($urandom);
         PC_In = $urandom;
         Val_Rn_In = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
         Val_Rm_In = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         Shift_operand_In = 12'($urandom);
         Signed_imm_24_In = 24'($urandom);
         cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_exe_stage
`default_nettype wire

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL expose: CLK  in  1  rising-edge clock.
REQ-002 SHALL expose: RST_N  in  1  reset, asynchronous, active-low.
REQ-003 SHALL expose: Stall  in  1  hold all output registers and the status register.
REQ-004 SHALL expose: WB_EN_In, MEM_R_EN_In, MEM_W_EN_In, B_In, S_In, imm_In  in  1 each  decoded controls from the ID/EX register.
REQ-005 SHALL expose: EXE_CMD_In  in  4  ALU command; Dest_In  in  4  destination register.
REQ-006 SHALL expose: PC_In, Val_Rn_In, Val_Rm_In  in  32 each  PC+4 and operand values.
REQ-007 SHALL expose: Shift_operand_In  in  12; Signed_imm_24_In  in  24.
REQ-008 SHALL expose: SR  out  4  status register {N,Z,C,V}, for the ID-stage condition check.
REQ-009 SHALL expose: Br_taken  out  1; Br_Addr  out  32  combinational branch outputs for IF and for flush.
REQ-010 SHALL expose: WB_EN_Out, MEM_R_EN_Out, MEM_W_EN_Out  out  1 each; ALU_Res_Out, Val_Rm_Out  out  32 each; Dest_Out  out  4  EX/MEM register outputs.

Function
REQ-011 Val2 SHALL be formed as follows:
- imm_In=1: {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
- Otherwise, MEM_R_EN_In|MEM_W_EN_In: zero-extended Shift_operand[11:0].
- Otherwise: Val_Rm shifted by Shift_operand[11:7], type Shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); shift amount 0 passes Val_Rm unchanged.
REQ-012 The ALU SHALL implement these commands:
- 0001 MOV=Val2; 1001 MVN=~Val2.
- 0010 ADD=Rn+Val2; 0011 ADC=Rn+Val2+C.
- 0100 SUB=Rn-Val2; 0101 SBC=Rn-Val2-!C.
- 0110 AND; 0111 ORR; 1000 EOR.
- All other codes yield 0 and leave C and V unchanged.
REQ-013 The 32-bit result SHALL wrap.
REQ-014 The flags SHALL be computed as:
- N = res[31]; Z = (res==0).
- C = carry-out for add, NOT borrow for subtract.
- V = signed overflow for add/sub.
- C and V SHALL be unchanged for logical/move commands.
REQ-015 SR SHALL load the new flags on the rising edge when S_In=1 and Stall=0; otherwise SR holds.
REQ-016 Br_taken SHALL equal B_In, combinationally.
REQ-017 Br_Addr SHALL equal PC_In + (sign_extend(Signed_imm_24_In) << 2), modulo 2^32.
REQ-018 With Stall=0, the EX/MEM outputs SHALL register ALU_Res, Val_Rm_In, Dest_In, WB_EN_In, MEM_R_EN_In and MEM_W_EN_In each cycle (latency 1 cycle).
REQ-019 With Stall=1, all registered outputs and SR SHALL hold; Br_taken and Br_Addr remain combinational.
REQ-020 ADC/SBC SHALL use the SR.C value registered before the current edge, never the flag being written in the same cycle.
REQ-021 When Stall and S_In are both 1, SR SHALL not update.

Reset
REQ-022 While RST_N=0, SR and all registered outputs SHALL be 0, regardless of clock or Stall.
REQ-023 A reset asserted mid-instruction SHALL discard that instruction entirely, including any pending flag update.
REQ-024 The first edge after RST_N rises SHALL capture normally.

Configuration
REQ-025 With macro EXE_OVF_FLAG_EN defined, V SHALL be computed per REQ-014.
REQ-026 Without EXE_OVF_FLAG_EN, SR.V SHALL be held at 0 and the overflow logic SHALL be absent.

Structure
REQ-027 The EXE_CMD encodings, shift-type encodings and flag bit positions SHALL live in the shared package exe_pkg.
REQ-028 The ALU plus flag generation SHALL be the sub-module exe_alu.
REQ-029 The Val2 generator and status/output registers SHALL reside in exe_stage.

Verification
REQ-030 ADD with S=1, Rn=0x7FFFFFFF, imm_In=1, Shift_operand=0x001 -> ALU_Res_Out=0x80000000 and SR=N1 Z0 C0 V1 one edge later (V=0 without EXE_OVF_FLAG_EN).
REQ-031 SUB with S=1, Rn=5, Val2=5 -> ALU_Res_Out=0 and SR=N0 Z1 C1 V0; a following ADC with Rn=1, Val2=1 -> ALU_Res_Out=3.
REQ-032 Immediate rotate with Shift_operand=0x4FF -> Val2=0xFF000000.
REQ-033 Register ASR #4 of Rm=0x80000010 -> Val2=0xF8000001.
REQ-034 B_In=1, PC_In=0x100, imm24=0xFFFFFE -> Br_taken=1, Br_Addr=0x0F8 in the same cycle.
REQ-035 Stall=1 for 3 cycles with S_In=1 -> outputs and SR unchanged.
REQ-036 RST_N pulsed low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
